// File: rtl/residual_extractor.sv
// Block-averages a 12-bit ADC stream over 2^LOG2_N samples, subtracts a setpoint from the
// scaled mean and emits a saturated signed 16-bit residual with a one-cycle strobe per window.
module residual_extractor #(
  parameter int unsigned LOG2_N = 3,
  parameter int unsigned SHIFT  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_sample_valid,
  input  logic [11:0]       i_sample,
  input  logic [15:0]       i_setpoint,
  output logic [15:0]       o_res,
  output logic              o_en,
  output logic              o_sat,
  output logic [LOG2_N-1:0] o_cnt
);

  localparam int unsigned AccW = 12 + LOG2_N;
  localparam int unsigned DiffW = 18;
  localparam logic [LOG2_N-1:0] CntLast = {LOG2_N{1'b1}};
  localparam logic signed [DiffW-1:0] ResMax = 18'sd32767;
  localparam logic signed [DiffW-1:0] ResMin = -18'sd32768;

  // Accumulator state
  logic [AccW-1:0]   r_acc;
  logic [LOG2_N-1:0] r_cnt;

  // Pipeline state
  logic [AccW-1:0]         r_sum;
  logic                    r_p1;
  logic signed [DiffW-1:0] r_diff;
  logic                    r_p2;

  // Output registers
  logic [15:0] r_res;
  logic        r_en;
  logic        r_sat;

  logic [AccW-1:0]         w_acc_sum;
  logic                    w_win_end;
  logic [11:0]             w_mean;
  logic [DiffW-1:0]        w_scaled;
  logic signed [DiffW-1:0] w_diff;
  logic                    w_sat_pos;
  logic                    w_sat_neg;

  assign w_acc_sum = r_acc + {{LOG2_N{1'b0}}, i_sample};
  // clear wins over a coincident sample, so no window end can be generated alongside it
  assign w_win_end = i_sample_valid && !i_clear && (r_cnt == CntLast);

  // Truncating mean: the upper 12 bits of the window sum
  assign w_mean    = r_sum[AccW-1:LOG2_N];
  assign w_scaled  = {{(DiffW - 12){1'b0}}, w_mean} << SHIFT;
  assign w_diff    = $signed(w_scaled) - $signed({2'b00, i_setpoint});

  assign w_sat_pos = (r_diff > ResMax);
  assign w_sat_neg = (r_diff < ResMin);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sum <= '0;
      r_p1  <= 1'b0;
    end else begin
      r_p1 <= w_win_end;
      if (i_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_sample_valid) begin
        if (r_cnt == CntLast) begin
          r_sum <= w_acc_sum;
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Stage 1 samples the setpoint in the cycle after the window end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_diff <= '0;
      r_p2   <= 1'b0;
    end else begin
      r_p2 <= r_p1;
      if (r_p1) begin
        r_diff <= w_diff;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_res <= '0;
      r_sat <= 1'b0;
      r_en  <= 1'b0;
    end else begin
      r_en <= r_p2;
      if (r_p2) begin
        if (w_sat_pos) begin
          r_res <= 16'h7fff;
          r_sat <= 1'b1;
        end else if (w_sat_neg) begin
          r_res <= 16'h8000;
          r_sat <= 1'b1;
        end else begin
          r_res <= r_diff[15:0];
          r_sat <= 1'b0;
        end
      end
    end
  end

  assign o_res = r_res;
  assign o_en  = r_en;
  assign o_sat = r_sat;
  assign o_cnt = r_cnt;

endmodule

// File: tb/tb_residual_extractor.sv
// Directed and randomized bench for residual_extractor, checked cycle by cycle against an
// arithmetic window/setpoint model.
module tb_residual_extractor;

  localparam int unsigned LOG2_N = 2;
  localparam int unsigned SHIFT  = 4;
  localparam int N = 1 << LOG2_N;

  logic              clk;
  logic              reset_n;
  logic              clear;
  logic              sample_valid;
  logic [11:0]       sample;
  logic [15:0]       setpoint;
  logic [15:0]       res;
  logic              en;
  logic              sat;
  logic [LOG2_N-1:0] cnt;

  residual_extractor #(
    .LOG2_N(LOG2_N),
    .SHIFT (SHIFT)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_clear       (clear),
    .i_sample_valid(sample_valid),
    .i_sample      (sample),
    .i_setpoint    (setpoint),
    .o_res         (res),
    .o_en          (en),
    .o_sat         (sat),
    .o_cnt         (cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_seen = 0;

  // Model: running window contents plus results awaiting their delivery cycle
  int          m_sum = 0;
  int          m_cnt = 0;
  logic [15:0] m_res = '0;
  logic        m_sat = 1'b0;
  logic        exp_en = 1'b0;
  int          pend_k[$];
  int          pend_sum[$];
  int          res_due[$];
  logic [15:0] res_val[$];
  logic        res_sat[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_sum = 0;
    m_cnt = 0;
    m_res = '0;
    m_sat = 1'b0;
    exp_en = 1'b0;
    pend_k.delete();
    pend_sum.delete();
    res_due.delete();
    res_val.delete();
    res_sat.delete();
  endtask

  task automatic model_edge(input logic v, input logic [11:0] s, input logic c);
    int mean;
    int diff;
    exp_en = 1'b0;
    if (res_due.size() > 0 && res_due[0] == cyc) begin
      exp_en = 1'b1;
      void'(res_due.pop_front());
      m_res = res_val.pop_front();
      m_sat = res_sat.pop_front();
    end
    // Setpoint is taken one cycle after the window closes; result appears one cycle later
    if (pend_k.size() > 0 && pend_k[0] + 1 == cyc) begin
      void'(pend_k.pop_front());
      mean = pend_sum.pop_front() / N;
      diff = mean * (1 << SHIFT) - int'(setpoint);
      if (diff > 32767) begin
        res_val.push_back(16'h7fff);
        res_sat.push_back(1'b1);
      end else if (diff < -32768) begin
        res_val.push_back(16'h8000);
        res_sat.push_back(1'b1);
      end else begin
        res_val.push_back(diff[15:0]);
        res_sat.push_back(1'b0);
      end
      res_due.push_back(cyc + 1);
    end
    if (c) begin
      m_sum = 0;
      m_cnt = 0;
    end else if (v) begin
      m_sum += int'(s);
      m_cnt++;
      if (m_cnt == N) begin
        pend_k.push_back(cyc);
        pend_sum.push_back(m_sum);
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [11:0] s, input logic c);
    sample_valid = v;
    sample = s;
    clear = c;
    @(posedge clk);
    cyc++;
    model_edge(v, s, c);
    #1;
    chk("en", {31'd0, en}, {31'd0, exp_en});
    chk("res", {16'd0, res}, {16'd0, m_res});
    chk("sat", {31'd0, sat}, {31'd0, m_sat});
    chk("cnt", {30'd0, cnt}, m_cnt);
    if (en) en_seen++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res"}, {16'd0, res}, 32'd0);
    chk({tag, "_en"}, {31'd0, en}, 32'd0);
    chk({tag, "_sat"}, {31'd0, sat}, 32'd0);
    chk({tag, "_cnt"}, {30'd0, cnt}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    setpoint = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    // Basic window: 10,20,30,40 with setpoint 100 -> 400-100 = 300
    setpoint = 16'd100;
    step(1'b1, 12'd10, 1'b0);
    step(1'b1, 12'd20, 1'b0);
    step(1'b1, 12'd30, 1'b0);
    step(1'b1, 12'd40, 1'b0);
    step(1'b0, 12'd0, 1'b0);
    chk("basic_en_early", {31'd0, en}, 32'd0);
    step(1'b0, 12'd0, 1'b0);
    chk("basic_en", {31'd0, en}, 32'd1);
    chk("basic_res", {16'd0, res}, 32'h012c);
    chk("basic_sat", {31'd0, sat}, 32'd0);
    step(1'b0, 12'd0, 1'b0);
    chk("basic_en_one_cycle", {31'd0, en}, 32'd0);
    chk("basic_res_hold", {16'd0, res}, 32'h012c);

    // Positive then negative saturation
    setpoint = 16'd0;
    repeat (4) step(1'b1, 12'd4095, 1'b0);
    repeat (2) step(1'b0, 12'd0, 1'b0);
    chk("pos_sat_res", {16'd0, res}, 32'h7fff);
    chk("pos_sat_sat", {31'd0, sat}, 32'd1);
    setpoint = 16'hffff;
    repeat (4) step(1'b1, 12'd0, 1'b0);
    repeat (2) step(1'b0, 12'd0, 1'b0);
    chk("neg_sat_res", {16'd0, res}, 32'h8000);
    chk("neg_sat_sat", {31'd0, sat}, 32'd1);

    // Continuous stream 0..15: means 1,5,9,13 -> last result 13<<4
    setpoint = 16'd0;
    en_seen = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 12'(i), 1'b0);
    repeat (2) step(1'b0, 12'd0, 1'b0);
    chk("stream_pulses", en_seen, 32'd4);
    chk("stream_last_res", {16'd0, res}, 32'd208);

    // Gapped samples then clear with a sample: only the clean window of 4s counts
    setpoint = 16'd20;
    en_seen = 0;
    step(1'b1, 12'd8, 1'b0);
    step(1'b0, 12'd0, 1'b0);
    step(1'b0, 12'd0, 1'b0);
    step(1'b1, 12'd8, 1'b0);
    step(1'b0, 12'd0, 1'b0);
    step(1'b1, 12'd9, 1'b1);
    chk("clear_cnt", {30'd0, cnt}, 32'd0);
    repeat (4) step(1'b1, 12'd4, 1'b0);
    repeat (3) step(1'b0, 12'd0, 1'b0);
    chk("clear_pulses", en_seen, 32'd1);
    chk("clear_res", {16'd0, res}, 32'd44);

    // Randomized traffic with occasional clears and setpoint changes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) setpoint = 16'($urandom);
      step(1'($urandom_range(3) != 0), 12'($urandom), 1'($urandom_range(19) == 0));
    end

    // Reset in the cycle after a window end loses the in-flight result
    step(1'b0, 12'd0, 1'b1);
    setpoint = 16'd0;
    repeat (4) step(1'b1, 12'd100, 1'b0);
    repeat (2) step(1'b0, 12'd0, 1'b0);
    chk("pre_reset_res", {16'd0, res}, 32'd1600);
    repeat (4) step(1'b1, 12'd50, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      cyc++;
      #1;
      chk_zero("in_reset");
    end
    reset_n = 1'b1;
    en_seen = 0;
    repeat (3) step(1'b1, 12'd200, 1'b0);
    repeat (5) step(1'b0, 12'd0, 1'b0);
    chk("post_reset_no_en", en_seen, 32'd0);
    step(1'b1, 12'd200, 1'b0);
    repeat (2) step(1'b0, 12'd0, 1'b0);
    chk("post_reset_pulses", en_seen, 32'd1);
    chk("post_reset_res", {16'd0, res}, 32'd3200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
